// File: rtl/rfill_sprite_renderer.sv
// Right-fill sprite renderer.
// Maps the current pixel onto the 584x167 sprite ROM, waits out the ROM
// latency, and composites the returned color over the background. A small
// press/hold FSM keeps the fill visible for HOLD_FRAMES frames after release.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | sprite disabled, no pixel hits
// ST_SHOW   | button held at the last frame_start, sprite drawn
// ST_HOLD   | button released, sprite drawn while cnt frames remain
module rfill_sprite_renderer #(
  parameter int          SPR_W        = 584,
  parameter int          SPR_H        = 167,
  parameter int          ROM_LAT      = 1,
  parameter logic [11:0] TRANSP_COLOR = 12'h000,
  parameter int          HOLD_FRAMES  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pix_valid,
  input  logic [11:0] bg_rgb,
  input  logic        frame_start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        btn,
  output logic [7:0]  rom_row,
  output logic [9:0]  rom_col,
  input  logic [11:0] color_data,
  output logic [11:0] rgb_out,
  output logic        rgb_valid,
  output logic        active
);

  localparam int              CNT_W     = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [10:0]     W11       = 11'(SPR_W);
  localparam logic [10:0]     H11       = 11'(SPR_H);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_HOLD
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [9:0]       px, py;

  // Frame-rate registers: FSM, hold counter, latched sprite position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      px     <= '0;
      py     <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      active <= (state_n != ST_IDLE);
      if (frame_start) begin
        px <= pos_x;
        py <= pos_y;
      end
    end
  end

  // Next-state logic; the FSM only moves on frame_start.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (frame_start) begin
      unique case (state)
        ST_IDLE: begin
          if (btn) state_n = ST_SHOW;
        end
        ST_SHOW: begin
          if (!btn) begin
            if (HOLD_FRAMES == 0) begin
              state_n = ST_IDLE;
            end else begin
              state_n = ST_HOLD;
              cnt_n   = HOLD_LOAD;
            end
          end
        end
        ST_HOLD: begin
          if (btn)                 state_n = ST_SHOW;
          else if (cnt <= CNT_ONE) state_n = ST_IDLE;
          else                     cnt_n   = cnt - CNT_ONE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Hit window in 11 bits so a sprite hanging off the screen edge cannot wrap.
  logic [10:0] x11, y11, px11, py11;
  logic        hit;

  assign x11  = {1'b0, pix_x};
  assign y11  = {1'b0, pix_y};
  assign px11 = {1'b0, px};
  assign py11 = {1'b0, py};
  assign hit  = pix_valid & active &
                (x11 >= px11) & (x11 < px11 + W11) &
                (y11 >= py11) & (y11 < py11 + H11);

  // Pixel flags delayed so that entry ROM_LAT lines up with color_data.
  logic        hit_p   [0:ROM_LAT];
  logic        valid_p [0:ROM_LAT];
  logic [11:0] bg_p    [0:ROM_LAT];

  // Stage 1 address generation plus the flag delay line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_row <= '0;
      rom_col <= '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        hit_p[i]   <= 1'b0;
        valid_p[i] <= 1'b0;
        bg_p[i]    <= '0;
      end
    end else begin
      // Offsets are below SPR_H/SPR_W on a hit, so the narrow subtraction is exact.
      rom_row    <= hit ? (pix_y[7:0] - py[7:0]) : 8'd0;
      rom_col    <= hit ? (pix_x - px) : 10'd0;
      hit_p[0]   <= hit;
      valid_p[0] <= pix_valid;
      bg_p[0]    <= bg_rgb;
      for (int i = 1; i <= ROM_LAT; i++) begin
        hit_p[i]   <= hit_p[i-1];
        valid_p[i] <= valid_p[i-1];
        bg_p[i]    <= bg_p[i-1];
      end
    end
  end

  // Stage 3 compositing: transparent ROM texels fall through to the background.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_out   <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= valid_p[ROM_LAT];
      if (!valid_p[ROM_LAT])
        rgb_out <= 12'h000;
      else if (hit_p[ROM_LAT] && (color_data != TRANSP_COLOR))
        rgb_out <= color_data;
      else
        rgb_out <= bg_p[ROM_LAT];
    end
  end

endmodule

// File: tb/tb_rfill_sprite_renderer.sv
// Bench for rfill_sprite_renderer: directed corner cases followed by random
// pixels and frames, checked through expectation queues against a frame-level
// visibility model and a behavioural ROM.
module tb_rfill_sprite_renderer;

  localparam int SPR_W = 584;
  localparam int SPR_H = 167;
  localparam int HOLD  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic        pix_valid = 1'b0;
  logic [11:0] bg_rgb = '0;
  logic        frame_start = 1'b0;
  logic [9:0]  pos_x = '0;
  logic [9:0]  pos_y = '0;
  logic        btn = 1'b0;
  logic [7:0]  rom_row;
  logic [9:0]  rom_col;
  logic [11:0] color_data = '0;
  logic [11:0] rgb_out;
  logic        rgb_valid;
  logic        active;

  rfill_sprite_renderer dut (
    .clk(clk), .reset(reset),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .bg_rgb(bg_rgb),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .btn(btn),
    .rom_row(rom_row), .rom_col(rom_col), .color_data(color_data),
    .rgb_out(rgb_out), .rgb_valid(rgb_valid), .active(active)
  );

  always #5 clk = ~clk;

  // Sprite ROM contents: (0,0) is white, a regular pattern of cells is transparent.
  function automatic logic [11:0] rom_fn(input int r, input int c);
    if (r == 0 && c == 0) return 12'hFFF;
    if ((r + c) % 5 == 1) return 12'h000;
    return 12'((r * 31 + c * 7 + 5) % 4096) | 12'h100;
  endfunction

  // One-clock-latency ROM.
  always @(posedge clk) color_data <= rom_fn(int'(rom_row), int'(rom_col));

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int due; logic [11:0] rgb; logic vld; } rexp_t;
  typedef struct { int due; logic [7:0] row; logic [9:0] col; logic act; } aexp_t;
  rexp_t rq[$];
  aexp_t aq[$];

  int checks = 0;
  int errors = 0;

  // Model: px/py latched per frame; m_left = frames of visibility remaining.
  int m_px = 0, m_py = 0, m_left = 0;

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input bit fs, input bit b, input int posx, input int posy,
                       input bit pv, input int x, input int y, input logic [11:0] bg);
    int xi, yi, row, col;
    bit hit;
    logic [11:0] c;
    rexp_t re;
    aexp_t ae;
    @(negedge clk);
    frame_start = fs; btn = b;
    pos_x = 10'(posx); pos_y = 10'(posy);
    pix_valid = pv; pix_x = 10'(x); pix_y = 10'(y); bg_rgb = bg;
    xi = int'(pix_x);
    yi = int'(pix_y);
    hit = pv && (m_left > 0) && xi >= m_px && xi < m_px + SPR_W && yi >= m_py && yi < m_py + SPR_H;
    row = hit ? yi - m_py : 0;
    col = hit ? xi - m_px : 0;
    c = rom_fn(row, col);
    re.due = cyc + 3;
    re.vld = pv;
    re.rgb = !pv ? 12'h000 : (hit && c != 12'h000) ? c : bg;
    if (fs) begin
      m_px = int'(pos_x);
      m_py = int'(pos_y);
      if (b) m_left = HOLD + 1;
      else if (m_left > 0) m_left--;
    end
    ae.due = cyc + 1;
    ae.row = 8'(row);
    ae.col = 10'(col);
    ae.act = (m_left > 0);
    aq.push_back(ae);
    rq.push_back(re);
  endtask

  task automatic idle();
    drive(1'b0, btn, int'(pos_x), int'(pos_y), 1'b0, 0, 0, 12'h000);
  endtask

  // Monitor: pops expectations as their output cycle arrives.
  aexp_t am;
  rexp_t rm;
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (aq.size() > 0 && aq[0].due == cyc) begin
        am = aq.pop_front();
        checks++;
        if (rom_row !== am.row || rom_col !== am.col || active !== am.act) begin
          errors++;
          $display("FAIL addr cyc=%0d: got row=%0d col=%0d act=%b expected row=%0d col=%0d act=%b",
                   cyc, rom_row, rom_col, active, am.row, am.col, am.act);
        end
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        rm = rq.pop_front();
        checks++;
        if (rgb_out !== rm.rgb || rgb_valid !== rm.vld) begin
          errors++;
          $display("FAIL rgb cyc=%0d: got rgb=%h vld=%b expected rgb=%h vld=%b",
                   cyc, rgb_out, rgb_valid, rm.rgb, rm.vld);
        end
      end else if (rgb_valid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL rgb_unexpected cyc=%0d: got vld=%b expected vld=0", cyc, rgb_valid);
      end
    end
  end

  initial begin
    int x, y, posx, posy, off, wait_n;
    bit fs, b, pv;

    // Power-on reset.
    repeat (2) @(negedge clk);
    chk("rst_rgb", rgb_out, 12'h000);
    chk("rst_vld", {11'd0, rgb_valid}, 12'h000);
    chk("rst_active", {11'd0, active}, 12'h000);
    chk("rst_row", {4'd0, rom_row}, 12'h000);
    chk("rst_col", {2'd0, rom_col}, 12'h000);
    reset = 1'b0;

    // Basic hit, miss and transparency at pos (28,100).
    drive(1, 1, 28, 100, 0, 0, 0, 12'h000);
    drive(0, 1, 28, 100, 1, 28, 100, 12'h123);
    drive(0, 1, 28, 100, 1, 27, 100, 12'h456);
    drive(0, 1, 28, 100, 1, 29, 100, 12'h0F0);
    drive(0, 1, 28, 100, 0, 29, 100, 12'h0F0);

    // Sprite corners and just-outside pixels at pos (0,0).
    drive(1, 1, 0, 0, 0, 0, 0, 12'h000);
    drive(0, 1, 0, 0, 1, 583, 166, 12'h777);
    drive(0, 1, 0, 0, 1, 584, 0, 12'h789);
    drive(0, 1, 0, 0, 1, 0, 167, 12'hABC);

    // Position change between frame starts is ignored until the next one.
    drive(1, 1, 28, 100, 1, 150, 100, 12'h001);
    drive(0, 1, 28, 100, 1, 50, 100, 12'h002);
    drive(0, 1, 100, 100, 1, 150, 100, 12'h003);
    drive(0, 1, 100, 100, 1, 150, 101, 12'h004);
    drive(1, 1, 100, 100, 1, 150, 100, 12'h005);
    drive(0, 1, 100, 100, 1, 150, 100, 12'h006);

    // Press/hold: two frames pressed, then released for ten frames.
    for (int f = 0; f < 12; f++) begin
      drive(1, f < 2, 0, 0, 1, 10, 10, 12'h0AA);
      drive(0, f < 2, 0, 0, 1, 10, 10, 12'h0AB);
    end
    // Re-press during hold, then release again.
    for (int f = 0; f < 16; f++) begin
      drive(1, (f < 2) || (f == 5), 0, 0, 1, 20, 5, 12'h0CC);
      drive(0, 1'b0, 0, 0, 1, 20, 5, 12'h0CD);
    end

    // Mid-line reset while output is valid.
    drive(1, 1, 0, 0, 0, 0, 0, 12'h000);
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 1, 40 + i, 3, 12'h321);
    @(posedge clk);
    #1;
    chk("pre_rst_vld", {11'd0, rgb_valid}, 12'h001);
    #2;
    reset = 1'b1;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    btn = 1'b0;
    #1;
    chk("midrst_rgb", rgb_out, 12'h000);
    chk("midrst_vld", {11'd0, rgb_valid}, 12'h000);
    chk("midrst_active", {11'd0, active}, 12'h000);
    chk("midrst_row", {4'd0, rom_row}, 12'h000);
    chk("midrst_col", {2'd0, rom_col}, 12'h000);
    aq.delete();
    rq.delete();
    m_left = 0; m_px = 0; m_py = 0;
    @(negedge clk);
    reset = 1'b0;
    // Sprite stays off after reset until a pressed frame_start.
    drive(1, 0, 0, 0, 1, 5, 5, 12'h111);
    drive(0, 0, 0, 0, 1, 5, 5, 12'h222);
    drive(1, 1, 0, 0, 1, 5, 5, 12'h333);
    drive(0, 1, 0, 0, 1, 5, 5, 12'h444);

    // Random frames and pixels.
    b = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      fs = ($urandom % 40) == 0;
      if (fs && ($urandom % 4) == 0) b = ~b;
      posx = ($urandom % 2) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 500));
      posy = ($urandom % 2) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 500));
      pv = ($urandom % 10) != 0;
      if ($urandom % 2) begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 1023));
      end else begin
        case ($urandom % 7)
          0: off = -1;
          1: off = 0;
          2: off = 1;
          3: off = SPR_W - 2;
          4: off = SPR_W - 1;
          5: off = SPR_W;
          default: off = int'($urandom_range(0, SPR_W - 1));
        endcase
        x = (m_px + off) & 1023;
        case ($urandom % 7)
          0: off = -1;
          1: off = 0;
          2: off = 1;
          3: off = SPR_H - 2;
          4: off = SPR_H - 1;
          5: off = SPR_H;
          default: off = int'($urandom_range(0, SPR_H - 1));
        endcase
        y = (m_py + off) & 1023;
      end
      drive(fs, b, posx, posy, pv, x, y, 12'($urandom));
    end

    // Drain.
    repeat (4) idle();
    wait_n = 0;
    while ((aq.size() > 0 || rq.size() > 0) && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    if (aq.size() > 0 || rq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", aq.size() + rq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
